// File: rtl/fir_tap_line.sv
// Parametrised tap delay line: holds the last DEPTH accepted samples, exposes
// all taps in parallel with a valid/ack handshake, fill tracking and a registered read port.
module fir_tap_line #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SEL_W = 3,
  parameter int unsigned PRIME = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  output logic [WIDTH*DEPTH-1:0] taps,
  output logic                   taps_valid,
  input  logic                   taps_ack,
  output logic [SEL_W:0]         fill_cnt,
  output logic                   primed,
  input  logic [SEL_W-1:0]       rd_sel,
  output logic [WIDTH-1:0]       rd_data
);

  localparam logic [SEL_W:0] FULL = (SEL_W+1)'(DEPTH);

  logic [WIDTH-1:0] tap_q [DEPTH];
  logic             accept;
  logic [SEL_W:0]   fill_next;
  logic [WIDTH-1:0] rd_next;

  assign in_ready  = !rst && !clr && (!taps_valid || taps_ack);
  assign accept    = in_valid && in_ready;
  assign fill_next = (fill_cnt == FULL) ? fill_cnt : fill_cnt + (SEL_W+1)'(1);
  assign primed    = (fill_cnt == FULL);

  genvar g;
  for (g = 0; g < DEPTH; g++) begin : g_pack
    assign taps[g*WIDTH +: WIDTH] = tap_q[g];
  end

  // Out-of-range selects match no tap and therefore read as zero.
  always_comb begin
    rd_next = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (rd_sel == SEL_W'(i)) rd_next = tap_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) tap_q[i] <= '0;
      fill_cnt <= '0;
    end else if (accept) begin
      tap_q[0] <= in_data;
      for (int unsigned i = 1; i < DEPTH; i++) tap_q[i] <= tap_q[i-1];
      fill_cnt <= fill_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      taps_valid <= 1'b0;
    end else if (accept && (PRIME == 0 || fill_next == FULL)) begin
      taps_valid <= 1'b1;
    end else if (taps_ack) begin
      taps_valid <= 1'b0;
    end
  end

  // Clear leaves the read port alone: it still captures the pre-clear taps.
  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= rd_next;
  end

endmodule

// File: tb/tb_fir_tap_line.sv
// Directed self-checking bench for fir_tap_line: a PRIME=1 DEPTH=4 instance
// plus a PRIME=0 DEPTH=3 instance for read-port range and unprimed valid.
module tb_fir_tap_line;

  logic        clk = 1'b0;
  logic        rst, clr, in_valid, in_ready, taps_valid, taps_ack, primed;
  logic [7:0]  in_data, rd_data;
  logic [31:0] taps;
  logic [2:0]  fill_cnt;
  logic [1:0]  rd_sel;

  logic        b_clr, b_in_valid, b_in_ready, b_taps_valid, b_taps_ack, b_primed;
  logic [7:0]  b_in_data, b_rd_data;
  logic [23:0] b_taps;
  logic [2:0]  b_fill_cnt;
  logic [1:0]  b_rd_sel;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fir_tap_line #(.WIDTH(8), .DEPTH(4), .SEL_W(2), .PRIME(1)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .taps(taps), .taps_valid(taps_valid), .taps_ack(taps_ack),
    .fill_cnt(fill_cnt), .primed(primed), .rd_sel(rd_sel), .rd_data(rd_data)
  );

  fir_tap_line #(.WIDTH(8), .DEPTH(3), .SEL_W(2), .PRIME(0)) dut_b (
    .clk(clk), .rst(rst), .clr(b_clr), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .taps(b_taps), .taps_valid(b_taps_valid), .taps_ack(b_taps_ack),
    .fill_cnt(b_fill_cnt), .primed(b_primed), .rd_sel(b_rd_sel), .rd_data(b_rd_data)
  );

  typedef struct {
    logic [7:0]  data;
    logic [2:0]  fill;
    logic        tv;
    logic [31:0] taps;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int i);
    in_valid = 1'b1;
    in_data  = vecs[i].data;
    taps_ack = 1'b1;
    tick();
    chk($sformatf("vec%0d fill", i), 32'(fill_cnt), 32'(vecs[i].fill));
    chk($sformatf("vec%0d taps_valid", i), 32'(taps_valid), 32'(vecs[i].tv));
    chk($sformatf("vec%0d taps", i), taps, vecs[i].taps);
    chk($sformatf("vec%0d primed", i), 32'(primed), 32'(vecs[i].fill == 3'd4));
  endtask

  initial begin
    // taps shown as {tap3,tap2,tap1,tap0}
    vecs[0] = '{8'h07, 3'd1, 1'b0, 32'h00000007};
    vecs[1] = '{8'h03, 3'd2, 1'b0, 32'h00000703};
    vecs[2] = '{8'h05, 3'd3, 1'b0, 32'h00070305};
    vecs[3] = '{8'h09, 3'd4, 1'b1, 32'h07030509};
    vecs[4] = '{8'h21, 3'd4, 1'b1, 32'h05091121};
    vecs[5] = '{8'h22, 3'd4, 1'b1, 32'h09112122};
    vecs[6] = '{8'h23, 3'd4, 1'b1, 32'h11212223};
    vecs[7] = '{8'h24, 3'd4, 1'b1, 32'h21222324};
    vecs[8] = '{8'h25, 3'd4, 1'b1, 32'h22232425};
    vecs[9] = '{8'h26, 3'd4, 1'b1, 32'h23242526};

    rst = 1'b1; clr = 1'b0; in_valid = 1'b1; in_data = 8'hFF; taps_ack = 1'b0; rd_sel = 2'd0;
    b_clr = 1'b0; b_in_valid = 1'b0; b_in_data = 8'h00; b_taps_ack = 1'b0; b_rd_sel = 2'd3;

    // Reset with a sample offered
    tick();
    chk("rst in_ready c1", 32'(in_ready), 32'd0);
    tick();
    chk("rst in_ready c2", 32'(in_ready), 32'd0);
    chk("rst taps", taps, 32'h0);
    chk("rst fill", 32'(fill_cnt), 32'd0);
    chk("rst taps_valid", 32'(taps_valid), 32'd0);
    chk("rst primed", 32'(primed), 32'd0);
    chk("rst rd_data", 32'(rd_data), 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("post-rst in_ready", 32'(in_ready), 32'd1);

    // Priming
    for (int i = 0; i < 4; i++) run_vec(i);

    // Backpressure: held for 5 cycles, then released by ack
    taps_ack = 1'b0; in_valid = 1'b1; in_data = 8'h11;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp in_ready", 32'(in_ready), 32'd0);
      tick();
      chk("bp taps frozen", taps, 32'h07030509);
      chk("bp fill", 32'(fill_cnt), 32'd4);
    end
    taps_ack = 1'b1;
    #1;
    chk("bp release in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("bp release taps", taps, 32'h03050911);
    chk("bp release taps_valid", 32'(taps_valid), 32'd1);

    // Saturation
    for (int i = 4; i < 10; i++) run_vec(i);

    // Read port; the ack with no accept consumes the set
    in_valid = 1'b0; rd_sel = 2'd2;
    tick();
    chk("rd tap2", 32'(rd_data), 32'h24);
    chk("ack consume taps_valid", 32'(taps_valid), 32'd0);
    rd_sel = 2'd3;
    tick();
    chk("rd tap3", 32'(rd_data), 32'h23);

    // Clear with a concurrent sample
    clr = 1'b1; in_valid = 1'b1; in_data = 8'h55; rd_sel = 2'd0;
    #1;
    chk("clr in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("clr taps", taps, 32'h0);
    chk("clr fill", 32'(fill_cnt), 32'd0);
    chk("clr taps_valid", 32'(taps_valid), 32'd0);
    chk("clr primed", 32'(primed), 32'd0);
    chk("clr rd_data pre-clear", 32'(rd_data), 32'h26);
    clr = 1'b0; in_data = 8'hAA;
    tick();
    chk("refill fill", 32'(fill_cnt), 32'd1);
    chk("refill taps_valid", 32'(taps_valid), 32'd0);
    chk("refill taps", taps, 32'h000000AA);
    in_valid = 1'b0;

    // PRIME=0, DEPTH=3 instance
    b_in_valid = 1'b1; b_in_data = 8'h5A;
    tick();
    chk("b first fill", 32'(b_fill_cnt), 32'd1);
    chk("b first taps_valid", 32'(b_taps_valid), 32'd1);
    b_taps_ack = 1'b1; b_in_data = 8'h6B;
    tick();
    b_in_data = 8'h7C;
    tick();
    b_in_data = 8'h8D;
    tick();
    chk("b fill sat", 32'(b_fill_cnt), 32'd3);
    chk("b taps", 32'(b_taps), 32'h006B7C8D);
    b_in_valid = 1'b0; b_taps_ack = 1'b0;
    tick();
    chk("b rd sel3 zero", 32'(b_rd_data), 32'd0);
    b_rd_sel = 2'd2;
    tick();
    chk("b rd tap2", 32'(b_rd_data), 32'h6B);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
